register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width in bits of every register.
REQ-002 SHALL have parameter ADDR_W, default 5: address width; depth is 2**ADDR_W registers.
REQ-003 SHALL have parameter ZERO_REG, default 1: 1 makes register 0 read as constant zero and ignore writes; 0 makes it a normal register.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port wr_en, input, 1 bit: write enable for the write port.
REQ-007 SHALL have port wr_addr, input, ADDR_W bits: write address.
REQ-008 SHALL have port wr_data, input, WIDTH bits: write data.
REQ-009 SHALL have port rd_addr_a, input, ADDR_W bits: read port A address.
REQ-010 SHALL have port rd_data_a, output, WIDTH bits: read port A data.
REQ-011 SHALL have port rd_addr_b, input, ADDR_W bits: read port B address.
REQ-012 SHALL have port rd_data_b, output, WIDTH bits: read port B data.

Function
REQ-013 SHALL hold 2**ADDR_W registers of WIDTH bits each.
REQ-014 SHALL, on a rising clk edge with reset=0 and wr_en=1, load wr_data into register wr_addr; all other registers unchanged.
REQ-015 SHALL, on a rising clk edge with wr_en=0, leave every register unchanged regardless of wr_addr/wr_data.
REQ-016 SHALL drive rd_data_a/rd_data_b combinationally from the register selected by rd_addr_a/rd_addr_b; zero-cycle read latency.
REQ-017 SHALL let both read ports address the same register, or any registers, in the same cycle independently.
REQ-018 SHALL, when ZERO_REG=1, discard writes to address 0 and return 0 on any read of address 0, including bypass reads.
REQ-019 SHALL change register contents only at the rising clk edge; wr_data changes between edges have no effect on stored state.
REQ-020 SHALL use the full ADDR_W address range; no out-of-range addresses exist.

Reset
REQ-021 SHALL, on a rising clk edge with reset=1, clear every register to 0; rd_data_a/rd_data_b then read 0 for any address.
REQ-022 SHALL give reset priority over a simultaneous write: wr_en=1 during reset is discarded.
REQ-023 SHALL not clear registers asynchronously; reset asserted between edges has no effect until the next rising edge.
REQ-024 SHALL resume normal writes on the first rising edge with reset=0.

Configuration
REQ-025 SHALL support macro REGISTER_FILE_BYPASS_EN compiled in or out.
REQ-026 SHALL, with REGISTER_FILE_BYPASS_EN defined, return wr_data on a read port when wr_en=1, reset=0 and rd_addr equals wr_addr (subject to REQ-018), same cycle as the write is presented.
REQ-027 SHALL, without REGISTER_FILE_BYPASS_EN, return the stored (pre-write) value in that case; new value visible after the edge.

Verification
REQ-028 Reset then read all addresses on both ports -> every rd_data = 0.
REQ-029 Write 50 to addr 3, then 100 to addr 7; read A=3, B=7 -> rd_data_a=50, rd_data_b=100.
REQ-030 wr_en=0, wr_addr=3, wr_data=89 across an edge -> addr 3 still reads 50.
REQ-031 ZERO_REG=1: write 0xDEADBEEF to addr 0 -> reads 0; ZERO_REG=0: same write -> reads 0xDEADBEEF.
REQ-032 Addr 5 holds 10; present wr_en=1, wr_addr=5, wr_data=40 with rd_addr_a=5 before the edge -> 40 with bypass macro, 10 without; 40 in both after the edge.
REQ-033 Addr 5 holds 40; reset=1 with wr_en=1, wr_addr=5, wr_data=30 at one edge -> addr 5 reads 0 after the edge.

Source files
------------

// File: rtl/register_file.sv
// register_file
//   Multi-ported register file: one synchronous write port and two
//   combinational read ports.
//
//   Parameters
//     WIDTH    - data width of every register (default 32)
//     ADDR_W   - address width; depth is 2**ADDR_W registers (default 5)
//     ZERO_REG - 1: register 0 reads as zero and ignores writes;
//                0: register 0 is an ordinary register (default 1)
//
//   Ports
//     clk        - clock; all state changes on its rising edge
//     reset      - synchronous active-high reset; clears every register
//     wr_en      - write enable
//     wr_addr    - write address
//     wr_data    - write data
//     rd_addr_a  - read port A address
//     rd_data_a  - read port A data (combinational)
//     rd_addr_b  - read port B address
//     rd_data_b  - read port B data (combinational)
//
//   Build option
//     REGISTER_FILE_BYPASS_EN - when defined, a read of the address being
//     written this cycle returns wr_data instead of the stored value.
module register_file #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] regs [DEPTH];
    logic             wr_allowed;

    // Writes to register 0 are dropped when it is hardwired to zero.
    assign wr_allowed = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_allowed) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Shared read-path selection for both ports. The zero-register check
    // sits ahead of the bypass so address 0 never forwards wr_data.
    function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [WIDTH-1:0] value;
        value = regs[addr];
`ifdef REGISTER_FILE_BYPASS_EN
        if (wr_en && !reset && (addr == wr_addr)) begin
            value = wr_data;
        end
`endif
        if ((ZERO_REG != 0) && (addr == '0)) begin
            value = '0;
        end
        return value;
    endfunction

    always_comb begin
        rd_data_a = read_port(rd_addr_a);
        rd_data_b = read_port(rd_addr_b);
    end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file
//   Randomized and directed bench for register_file. Two instances share
//   all stimulus: one with register 0 hardwired to zero, one without.
//   A reference model (plain arrays) tracks expected contents.
module tb_register_file;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;
`ifdef REGISTER_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [WIDTH-1:0]  z_rd_a, z_rd_b;   // ZERO_REG=1 instance
    logic [WIDTH-1:0]  n_rd_a, n_rd_b;   // ZERO_REG=0 instance

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    logic [WIDTH-1:0] mz [DEPTH];
    logic [WIDTH-1:0] mn [DEPTH];

    register_file #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut_z (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(z_rd_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(z_rd_b)
    );

    register_file #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(0)) dut_n (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(n_rd_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(n_rd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents after each rising edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mz[i] = '0;
                mn[i] = '0;
            end
        end else if (wr_en) begin
            if (wr_addr != 0) mz[wr_addr] = wr_data;
            mn[wr_addr] = wr_data;
        end
    end

    function automatic logic [WIDTH-1:0] expect_read(input bit zr, input logic [ADDR_W-1:0] addr);
        if (zr && addr == 0) return '0;
        if (BYP && wr_en && !reset && addr == wr_addr) return wr_data;
        return zr ? mz[addr] : mn[addr];
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison on the falling edge, inputs stable.
    always @(negedge clk) begin
        if (checking) begin
            check("cmp_z_a", z_rd_a, expect_read(1'b1, rd_addr_a));
            check("cmp_z_b", z_rd_b, expect_read(1'b1, rd_addr_b));
            check("cmp_n_a", n_rd_a, expect_read(1'b0, rd_addr_a));
            check("cmp_n_b", n_rd_b, expect_read(1'b0, rd_addr_b));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'd123;
        rd_addr_a = '0; rd_addr_b = '0;
        tick();
        checking = 1'b1;
        tick();

        // After reset every address reads zero on both ports.
        reset = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(DEPTH - 1 - i);
            #1;
            check("reset_read_a", n_rd_a, 32'd0);
            check("reset_read_b", n_rd_b, 32'd0);
            tick();
        end

        // Two writes, then simultaneous reads.
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd50;
        tick();
        wr_addr = 5'd7; wr_data = 32'd100;
        tick();
        wr_en = 1'b0; rd_addr_a = 5'd3; rd_addr_b = 5'd7;
        #1;
        check("write3_read_a", z_rd_a, 32'd50);
        check("write7_read_b", z_rd_b, 32'd100);
        check("write3_read_a_n", n_rd_a, 32'd50);

        // Disabled write must not modify storage.
        wr_addr = 5'd3; wr_data = 32'd89;
        tick();
        wr_data = 32'd77;
        #1;
        check("no_write_keep", z_rd_a, 32'd50);

        // Register 0 behaviour.
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF; rd_addr_a = 5'd0;
        tick();
        wr_en = 1'b0;
        #1;
        check("zero_reg_z", z_rd_a, 32'd0);
        check("zero_reg_n", n_rd_a, 32'hDEADBEEF);

        // Write-through vs stored value on a same-cycle read.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'd10; rd_addr_a = 5'd5;
        tick();
        wr_data = 32'd40;
        #1;
        check("same_cycle_read", z_rd_a, BYP ? 32'd40 : 32'd10);
        tick();
        wr_en = 1'b0;
        #1;
        check("after_edge_read", z_rd_a, 32'd40);

        // Reset raised mid-cycle with a pending write: nothing changes
        // until the edge, then everything clears and the write is lost.
        reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'd30;
        #1;
        check("reset_not_async", z_rd_a, 32'd40);
        tick();
        reset = 1'b0; wr_en = 1'b0;
        #1;
        check("reset_beats_write", z_rd_a, 32'd0);
        check("reset_beats_write_n", n_rd_a, 32'd0);

        // First edge out of reset accepts writes again.
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1234_5678; rd_addr_b = 5'd9;
        tick();
        wr_en = 1'b0;
        #1;
        check("resume_write", z_rd_b, 32'h1234_5678);

        // Random traffic, biased toward a small address set for collisions.
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 99) == 0);
            wr_en     = ($urandom_range(0, 3) != 0);
            wr_addr   = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            wr_data   = $urandom;
            rd_addr_a = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 3));
            rd_addr_b = 5'($urandom);
            tick();
        end

        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
